// File: rtl/pll_reset_sequencer.sv
// ============================================================================
//  Module   : pll_reset_sequencer
//  Brief    : PLL bring-up sequencer: reset pulse, lock wait with retry,
//             lock qualification, core reset release and loss-of-lock handling.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  output logic       pll_rst,
  output logic       core_reset_n,
  output logic       ready,
  output logic       lock_lost,
  output logic       fault,
  output logic [1:0] retry_count,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic             lost_q, lost_d;
  logic             sync1_q, sync2_q;
  logic             pll_rst_q, pll_rst_d;
  logic             core_rst_n_q, core_rst_n_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic             locked_s;

  assign locked_s = sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      state_q      <= ST_RESET_PLL;
      cnt_q        <= '0;
      retry_q      <= 2'd0;
      lost_q       <= 1'b0;
      pll_rst_q    <= 1'b1;
      core_rst_n_q <= 1'b0;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      sync1_q      <= pll_locked;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      lost_q       <= lost_d;
      pll_rst_q    <= pll_rst_d;
      core_rst_n_q <= core_rst_n_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
    end
  end

  // Counter holds in RUN/FAULT so it can never wrap; every transition clears it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    lost_d  = lost_q;

    if (soft_reset_req) begin
      state_d = ST_RESET_PLL;
      cnt_d   = '0;
      retry_d = 2'd0;
      lost_d  = 1'b0;
    end else begin
      case (state_q)
        ST_RESET_PLL: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          cnt_d = cnt_q + 1'b1;
          if (locked_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            retry_d = retry_q + 2'd1;
            state_d = (retry_d == RETRY_MAX) ? ST_FAULT : ST_RESET_PLL;
            cnt_d   = '0;
          end
        end
        ST_STABLE: begin
          cnt_d = cnt_q + 1'b1;
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            retry_d = 2'd0;
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_d = ST_RESET_PLL;
            cnt_d   = '0;
            lost_d  = 1'b1;
          end
        end
        ST_FAULT: begin
        end
        default: begin
          state_d = ST_RESET_PLL;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are registered from the next state so they change on the transition edge.
    pll_rst_d    = (state_d == ST_RESET_PLL);
    core_rst_n_d = (state_d == ST_RUN);
    ready_d      = (state_d == ST_RUN);
    fault_d      = (state_d == ST_FAULT);
  end

  assign pll_rst      = pll_rst_q;
  assign core_reset_n = core_rst_n_q;
  assign ready        = ready_q;
  assign lock_lost    = lost_q;
  assign fault        = fault_q;
  assign retry_count  = retry_q;
  assign state_o      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
// ============================================================================
//  Module   : tb_pll_reset_sequencer
//  Brief    : Scoreboard bench for pll_reset_sequencer with a phase/elapsed-time
//             reference model and directed plus randomized lock/reset stimulus.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pll_reset_sequencer;

  localparam int RSTC = 4;
  localparam int TO   = 32;
  localparam int STB  = 8;
  localparam int MAXR = 3;
  localparam int CW   = 6;

  localparam int P_RP  = 0;
  localparam int P_WL  = 1;
  localparam int P_ST  = 2;
  localparam int P_RUN = 3;
  localparam int P_FLT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       soft_reset_req;
  logic       pll_rst;
  logic       core_reset_n;
  logic       ready;
  logic       lock_lost;
  logic       fault;
  logic [1:0] retry_count;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .RST_CYCLES   (RSTC),
    .LOCK_TIMEOUT (TO),
    .STABLE_CYCLES(STB),
    .MAX_RETRIES  (MAXR),
    .CNT_W        (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .soft_reset_req(soft_reset_req),
    .pll_rst       (pll_rst),
    .core_reset_n  (core_reset_n),
    .ready         (ready),
    .lock_lost     (lock_lost),
    .fault         (fault),
    .retry_count   (retry_count),
    .state_o       (state_o)
  );

  typedef struct packed {
    logic       pll_rst;
    logic       core_reset_n;
    logic       ready;
    logic       lock_lost;
    logic       fault;
    logic [1:0] retry;
    logic [2:0] st;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: current phase, edge index at which it was entered,
  // and the raw pll_locked samples still travelling through the synchroniser.
  int   m_phase = P_RP;
  int   m_start = 0;
  int   m_cyc   = 0;
  int   m_retry = 0;
  bit   m_lost  = 1'b0;
  bit   hist[$] = '{1'b0, 1'b0};

  function automatic void chk(string nm, logic [2:0] act, logic [2:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, expv);
    end
  endfunction

  function automatic void enter(int p);
    m_phase = p;
    m_start = m_cyc;
  endfunction

  function automatic void model_step(bit rn, bit lk, bit sr);
    int   el;
    bit   ls;
    exp_t e;
    m_cyc++;
    if (!rn) begin
      enter(P_RP);
      m_retry = 0;
      m_lost  = 1'b0;
      hist    = '{1'b0, 1'b0};
    end else begin
      ls = hist.pop_front();
      hist.push_back(lk);
      el = m_cyc - m_start;
      if (sr) begin
        enter(P_RP);
        m_retry = 0;
        m_lost  = 1'b0;
      end else begin
        case (m_phase)
          P_RP:  if (el == RSTC) enter(P_WL);
          P_WL: begin
            if (ls) enter(P_ST);
            else if (el == TO) begin
              m_retry++;
              enter((m_retry == MAXR) ? P_FLT : P_RP);
            end
          end
          P_ST: begin
            if (!ls) enter(P_WL);
            else if (el == STB) begin
              m_retry = 0;
              enter(P_RUN);
            end
          end
          P_RUN: begin
            if (!ls) begin
              m_lost = 1'b1;
              enter(P_RP);
            end
          end
          default: ;
        endcase
      end
    end
    e.pll_rst      = (m_phase == P_RP);
    e.core_reset_n = (m_phase == P_RUN);
    e.ready        = (m_phase == P_RUN);
    e.fault        = (m_phase == P_FLT);
    e.lock_lost    = m_lost;
    e.retry        = 2'(m_retry);
    e.st           = 3'(m_phase);
    exp_q.push_back(e);
  endfunction

  task automatic drive(input bit rn, input bit lk, input bit sr);
    @(negedge clk);
    rst_n          = rn;
    pll_locked     = lk;
    soft_reset_req = sr;
    model_step(rn, lk, sr);
  endtask

  task automatic hold(input int n, input bit lk);
    for (int i = 0; i < n; i++) drive(1'b1, lk, 1'b0);
  endtask

  // Monitor: outputs are valid every cycle; compare one expectation per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pll_rst",      {2'b0, pll_rst},      {2'b0, e.pll_rst});
        chk("core_reset_n", {2'b0, core_reset_n}, {2'b0, e.core_reset_n});
        chk("ready",        {2'b0, ready},        {2'b0, e.ready});
        chk("lock_lost",    {2'b0, lock_lost},    {2'b0, e.lock_lost});
        chk("fault",        {2'b0, fault},        {2'b0, e.fault});
        chk("retry_count",  {1'b0, retry_count},  {1'b0, e.retry});
        chk("state_o",      state_o,              e.st);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit lk;
    rst_n          = 1'b0;
    pll_locked     = 1'b0;
    soft_reset_req = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 1'b0);

    // Power-up, lock arrives later and holds into RUN
    hold(10, 1'b0);
    hold(25, 1'b1);

    // Loss of lock in RUN, then re-lock
    hold($urandom_range(3, 6), 1'b0);
    hold(30, 1'b1);

    // Single-cycle lock glitch during qualification
    hold(12, 1'b0);
    hold(7, 1'b1);
    hold(1, 1'b0);
    hold(25, 1'b1);

    // Soft reset coinciding with lock loss in RUN
    drive(1'b1, 1'b0, 1'b1);
    hold(30, 1'b1);

    // Lock never arrives: retries exhaust into FAULT
    drive(1'b1, 1'b1, 1'b1);
    hold(3 * (RSTC + TO) + 20, 1'b0);

    // Soft reset held a few cycles out of FAULT
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1);
    hold($urandom_range(2, 12), 1'b0);
    hold(30, 1'b1);

    // Async reset mid-WAIT_LOCK
    hold(9, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    #1;
    chk("async pll_rst",      {2'b0, pll_rst},      3'd1);
    chk("async core_reset_n", {2'b0, core_reset_n}, 3'd0);
    chk("async ready",        {2'b0, ready},        3'd0);
    chk("async lock_lost",    {2'b0, lock_lost},    3'd0);
    chk("async fault",        {2'b0, fault},        3'd0);
    chk("async retry_count",  {1'b0, retry_count},  3'd0);
    chk("async state_o",      state_o,              3'd0);
    drive(1'b0, 1'b0, 1'b0);
    hold($urandom_range(3, 15), 1'b0);
    hold(30, 1'b1);

    // Randomized lock behaviour, soft resets and occasional rst_n pulses
    lk = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) lk = ~lk;
      drive(($urandom_range(0, 199) != 0), lk, ($urandom_range(0, 59) == 0));
    end
    hold(3, lk);

    @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
